// File: rtl/movelist_ctrl.sv
// Move-list controller: captures LMG move lists into a move RAM as a
// stack of nested frames, readable over a fixed-latency Avalon-MM port.
module movelist_ctrl #(
    parameter int MOVE_W    = 16,
    parameter int RAM_AW    = 10,
    parameter int DEPTH_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mv_valid,
    input  logic [MOVE_W-1:0] mv_data,
    output logic              mv_ready,
    input  logic              gen_done,
    input  logic              push,
    input  logic              pop,
    output logic              filling,
    input  logic [RAM_AW:0]   avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state;
    logic [7:0]        depth;
    logic [RAM_AW:0]   wp;
    logic [RAM_AW:0]   start [1:DEPTH_MAX];
    logic [RAM_AW:0]   count [1:DEPTH_MAX];
    logic              ovf;
    logic              cmd_err;
    logic [MOVE_W-1:0] ram [0:(1<<RAM_AW)-1];

    logic              clr;
    logic              full;
    logic              accept;
    logic              store;
    logic [RAM_AW-1:0] sel;
    logic [RAM_AW:0]   top_start;
    logic [31:0]       status_word;
    logic [31:0]       reg_word;
    logic [31:0]       ram_word;
    logic              unused_wdata;

    assign sel          = avs_address[RAM_AW-1:0];
    assign clr          = avs_write && avs_address[RAM_AW]
                          && (sel == '0) && avs_writedata[0];
    // wp saturates at 2^RAM_AW, so its MSB alone flags a full RAM
    assign full         = wp[RAM_AW];
    assign accept       = mv_valid && mv_ready;
    assign store        = accept && !full && !reset && !clr;
    assign unused_wdata = ^avs_writedata[31:1];

    always_comb begin
        top_start = '0;
        for (int k = 1; k <= DEPTH_MAX; k++) begin
            if (depth == 8'(k)) top_start = start[k];
        end
    end

    always_comb begin
        status_word                 = '0;
        status_word[7:0]            = depth;
        status_word[8]              = filling;
        status_word[9]              = ovf;
        status_word[10]             = cmd_err;
        status_word[16 +: RAM_AW+1] = wp;
    end

    always_comb begin
        reg_word = (sel == '0) ? status_word : '0;
        for (int k = 1; k <= DEPTH_MAX; k++) begin
            if (32'(sel) == k) begin
                reg_word                 = '0;
                reg_word[16 +: RAM_AW+1] = count[k];
                reg_word[0 +: RAM_AW+1]  = start[k];
            end
        end
    end

    always_comb begin
        ram_word             = '0;
        ram_word[MOVE_W-1:0] = ram[sel];
    end

    // Frame-stack FSM; soft clear shares the reset path but spares the RAM
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            state    <= IDLE;
            depth    <= '0;
            wp       <= '0;
            ovf      <= 1'b0;
            cmd_err  <= 1'b0;
            mv_ready <= 1'b0;
            filling  <= 1'b0;
            for (int k = 1; k <= DEPTH_MAX; k++) begin
                start[k] <= '0;
                count[k] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (push && pop) begin
                        cmd_err <= 1'b1;
                    end else if (push) begin
                        if (depth == 8'(DEPTH_MAX)) begin
                            cmd_err <= 1'b1;
                        end else begin
                            for (int k = 1; k <= DEPTH_MAX; k++) begin
                                if (8'(k) == depth + 8'd1) begin
                                    start[k] <= wp;
                                    count[k] <= '0;
                                end
                            end
                            depth    <= depth + 8'd1;
                            state    <= FILL;
                            mv_ready <= 1'b1;
                            filling  <= 1'b1;
                        end
                    end else if (pop) begin
                        if (depth == 8'd0) begin
                            cmd_err <= 1'b1;
                        end else begin
                            for (int k = 1; k <= DEPTH_MAX; k++) begin
                                if (depth == 8'(k)) begin
                                    start[k] <= '0;
                                    count[k] <= '0;
                                end
                            end
                            wp    <= top_start;
                            depth <= depth - 8'd1;
                        end
                    end
                end
                FILL: begin
                    if (push || pop) cmd_err <= 1'b1;
                    if (accept) begin
                        if (full) begin
                            ovf <= 1'b1;
                        end else begin
                            wp <= wp + 1'b1;
                            for (int k = 1; k <= DEPTH_MAX; k++) begin
                                if (depth == 8'(k)) count[k] <= count[k] + 1'b1;
                            end
                        end
                    end
                    if (gen_done) begin
                        state    <= IDLE;
                        mv_ready <= 1'b0;
                        filling  <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (store) ram[wp[RAM_AW-1:0]] <= mv_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) begin
                avs_readdata <= avs_address[RAM_AW] ? reg_word : ram_word;
            end
        end
    end

endmodule

// File: tb/tb_movelist_ctrl.sv
// Directed bench for movelist_ctrl with a read scoreboard; small RAM and
// stack so the full-RAM and full-stack corners are reachable.
module tb_movelist_ctrl;

    localparam int MOVE_W    = 16;
    localparam int RAM_AW    = 3;
    localparam int DEPTH_MAX = 2;
    localparam logic [RAM_AW:0] STATUS = 4'b1000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              mv_valid = 1'b0;
    logic [MOVE_W-1:0] mv_data = '0;
    logic              mv_ready;
    logic              gen_done = 1'b0;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic              filling;
    logic [RAM_AW:0]   avs_address = '0;
    logic              avs_read = 1'b0;
    logic              avs_write = 1'b0;
    logic [31:0]       avs_writedata = '0;
    logic [31:0]       avs_readdata;
    logic              avs_readdatavalid;

    int          total = 0;
    int          passed = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    movelist_ctrl #(
        .MOVE_W   (MOVE_W),
        .RAM_AW   (RAM_AW),
        .DEPTH_MAX(DEPTH_MAX)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .mv_valid         (mv_valid),
        .mv_data          (mv_data),
        .mv_ready         (mv_ready),
        .gen_done         (gen_done),
        .push             (push),
        .pop              (pop),
        .filling          (filling),
        .avs_address      (avs_address),
        .avs_read         (avs_read),
        .avs_write        (avs_write),
        .avs_writedata    (avs_writedata),
        .avs_readdata     (avs_readdata),
        .avs_readdatavalid(avs_readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [RAM_AW:0] reg_a(input int k);
        logic [RAM_AW-1:0] lo;
        lo = RAM_AW'(k);
        return {1'b1, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [RAM_AW:0] a, input logic [31:0] e,
                      input string tag);
        avs_read    = 1'b1;
        avs_address = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        tick();
        avs_read = 1'b0;
    endtask

    task automatic wr(input logic [RAM_AW:0] a, input logic [31:0] d);
        avs_write     = 1'b1;
        avs_address   = a;
        avs_writedata = d;
        tick();
        avs_write     = 1'b0;
        avs_writedata = '0;
    endtask

    task automatic do_push();
        push = 1'b1;
        tick();
        push = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        tick();
    endtask

    task automatic stream(input int n, input logic [15:0] base,
                          input logic [15:0] step, input string tag);
        for (int i = 0; i < n; i++) begin
            mv_valid = 1'b1;
            mv_data  = base + step * 16'(i);
            gen_done = (i == n - 1);
            check(tag, 32'(mv_ready), 32'd1);
            tick();
        end
        mv_valid = 1'b0;
        gen_done = 1'b0;
    endtask

    // Scoreboard: every valid read beat must match the oldest pending read
    always @(negedge clk) begin
        if (avs_readdatavalid) begin
            if (exp_q.size() == 0) begin
                total++;
                $error("FAIL rd_unexpected: observed valid expected none");
            end else begin
                check(tag_q.pop_front(), avs_readdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", 32'(mv_ready), 32'd0);
        check("rst_filling", 32'(filling), 32'd0);
        check("rst_rdata", avs_readdata, 32'd0);
        check("rst_rvalid", 32'(avs_readdatavalid), 32'd0);
        rd(STATUS, 32'h0000_0000, "rst_status");

        do_push();
        check("push_ready", 32'(mv_ready), 32'd1);
        check("push_filling", 32'(filling), 32'd1);
        stream(3, 16'h0101, 16'h0101, "f1_ready");
        check("done_ready", 32'(mv_ready), 32'd0);
        check("done_filling", 32'(filling), 32'd0);
        rd(reg_a(1), 32'h0003_0000, "f1_tag");
        rd(4'd0, 32'h0000_0101, "f1_ram0");
        rd(4'd1, 32'h0000_0202, "f1_ram1");
        rd(4'd2, 32'h0000_0303, "f1_ram2");
        rd(STATUS, 32'h0003_0001, "f1_status");

        do_push();
        stream(2, 16'h0404, 16'h0101, "f2_ready");
        rd(reg_a(2), 32'h0002_0003, "f2_tag");
        rd(STATUS, 32'h0005_0002, "f2_status");
        do_pop();
        rd(STATUS, 32'h0003_0001, "pop_status");
        rd(reg_a(2), 32'h0000_0000, "pop_tag");
        rd(reg_a(1), 32'h0003_0000, "pop_f1_tag");

        do_push();
        stream(1, 16'h0606, 16'h0000, "f2b_ready");
        rd(4'd3, 32'h0000_0606, "f2b_ram3");
        rd(reg_a(2), 32'h0001_0003, "f2b_tag");

        do_push();
        check("stackfull_ready", 32'(mv_ready), 32'd0);
        rd(STATUS, 32'h0004_0402, "stackfull_status");
        do_pop();
        do_pop();
        do_pop();
        rd(STATUS, 32'h0000_0400, "pop3_status");

        wr(STATUS, 32'd1);
        rd(STATUS, 32'h0000_0000, "clr_status");
        do_push();
        stream(10, 16'h1000, 16'h0001, "ovf_ready");
        rd(STATUS, 32'h0008_0201, "ovf_status");
        rd(reg_a(1), 32'h0008_0000, "ovf_tag");
        rd(4'd0, 32'h0000_1000, "ovf_ram0");
        rd(4'd7, 32'h0000_1007, "ovf_ram7");

        wr(STATUS, 32'd1);
        do_push();
        mv_valid = 1'b1;
        mv_data  = 16'h2222;
        tick();
        mv_data       = 16'h3333;
        avs_write     = 1'b1;
        avs_address   = STATUS;
        avs_writedata = 32'd1;
        tick();
        mv_valid      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        check("sclr_ready", 32'(mv_ready), 32'd0);
        check("sclr_filling", 32'(filling), 32'd0);
        rd(STATUS, 32'h0000_0000, "sclr_status");
        rd(reg_a(1), 32'h0000_0000, "sclr_tag");
        rd(4'd0, 32'h0000_2222, "sclr_ram0");
        rd(4'd1, 32'h0000_1001, "sclr_ram1");

        push = 1'b1;
        pop  = 1'b1;
        tick();
        push     = 1'b0;
        pop      = 1'b0;
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        check("pushpop_ready", 32'(mv_ready), 32'd0);
        rd(STATUS, 32'h0000_0400, "pushpop_status");

        repeat (3) tick();
        check("rd_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/movelist_ctrl.md
# movelist_ctrl

Parametrised move-list controller between the legal move generator (LMG) output stream and the Avalon-MM slave that software reads. It captures each generated move list into an on-chip move RAM as a "frame", and keeps a stack of up to DEPTH_MAX nested frames so a multi-depth search can push and pop plies. Software reads moves, per-frame {start, count} tags and status over a fixed-latency Avalon read port. It supersedes the single-depth capture-and-wait sequencing of the top-level controller.

## Interface
- MOVE_W, 16: move word width (from 6 b, to 6 b, flags 4 b); 1..32, zero-extended on readout.
- RAM_AW, 10: move RAM address width; 2^RAM_AW entries; at most 15.
- DEPTH_MAX, 4: maximum number of stacked frames; 1..255.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high.
- mv_valid  in  1  LMG move word valid.
- mv_data  in  MOVE_W  LMG move word.
- mv_ready  out  1  move accepted when mv_valid && mv_ready.
- gen_done  in  1  one-cycle pulse: LMG finished the current list; closes the open frame.
- push  in  1  one-cycle pulse: open a new frame at depth+1.
- pop  in  1  one-cycle pulse: discard the top frame and reclaim its entries.
- filling  out  1  a frame is open and accepting moves.
- avs_address  in  RAM_AW+1  MSB=0: move RAM word; MSB=1: register space (low bits select the register).
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe; register space only.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data.
- avs_readdatavalid  out  1  high exactly one cycle after an accepted read.

## Operation
- State: depth (0..DEPTH_MAX), write pointer wp (RAM_AW+1 bits), frame table start[k]/count[k] for k = 1..DEPTH_MAX, FSM {IDLE, FILL}, sticky flags ovf and cmd_err.
- IDLE + push, depth < DEPTH_MAX: depth++, start[depth] <= wp, count[depth] <= 0, go to FILL.
- IDLE + push, depth == DEPTH_MAX: ignored; cmd_err set.
- IDLE + pop, depth > 0: wp <= start[depth], count[depth] <= 0, start[depth] <= 0, depth--.
- IDLE + pop, depth == 0: ignored; cmd_err set.
- push and pop in the same cycle: both ignored; cmd_err set.
- FILL: mv_ready = 1. On an accepted move with wp < 2^RAM_AW: RAM[wp] <= mv_data, wp++, count[depth]++.
- FILL, accepted move with wp == 2^RAM_AW (RAM full): move dropped (still handshaken, so the LMG drains), ovf set, count unchanged.
- FILL + gen_done: go to IDLE. A move accepted in the same cycle is stored first.
- gen_done in IDLE: ignored; no flag.
- push or pop in FILL: ignored; cmd_err set.
- Register map (MSB=1):
  - Register 0, STATUS:
    - [7:0] depth
    - [8] filling
    - [9] ovf
    - [10] cmd_err
    - [31:16] wp, zero-extended.
  - Register k = 1..DEPTH_MAX: {count[k] in [31:16], start[k] in [15:0]}.
  - Any other register reads 0.
- Move RAM read (MSB=0): returns {0, RAM[addr]}. Reads are allowed in any state. A location never written returns undefined data; software bounds reads by the frame tags.
- Write to STATUS with writedata[0]=1 (soft clear): same effect as reset, except move RAM contents are kept. It wins over push, pop, moves and gen_done in the same cycle. Writes to any other address are ignored.

## Timing
- Reset values:
  - depth=0, wp=0, FSM=IDLE
  - mv_ready=0, filling=0
  - ovf=0, cmd_err=0
  - all start/count = 0
  - avs_readdata=0, avs_readdatavalid=0.
- Reset or soft clear mid-FILL aborts the frame. mv_ready is low on the following cycle.
- mv_ready and filling are registered:
  - High the cycle after a successful push.
  - Low the cycle after gen_done.
- Move write latency: a move accepted in cycle n is readable from RAM by a read issued in cycle n+1. count and wp are visible in a register read issued in cycle n+1.
- Register and RAM reads have a fixed latency of 1. The value returned is the state as of the end of the read cycle. No waitrequest; a read may be issued every cycle.
- Throughput: one move per cycle in FILL.

## Test plan
- Reset, then read STATUS -> readdatavalid one cycle later, readdata=0; mv_ready=0.
- push; stream moves 0x0101, 0x0202, 0x0303 back-to-back with gen_done on the third -> frame 1 reads {count=3, start=0}; RAM[0..2]=0x0101/0x0202/0x0303; STATUS depth=1, wp=3, filling=0.
- From that state, push and stream 2 moves, then pop -> before pop, frame 2 reads {2, 3}; after pop, depth=1, wp=3, frame 2 reads 0. Push again: the next move lands at RAM[3].
- RAM_AW=2: push and stream 6 moves -> count=4, wp=4, ovf=1, mv_ready high for all 6 moves.
- DEPTH_MAX=2: push, done, push, done, push -> depth stays 2, cmd_err=1. Then pop, pop, pop -> depth=0, cmd_err remains 1.
- Soft clear during FILL, on the same cycle as an accepted move -> next cycle mv_ready=0, depth=0, wp=0, count[1]=0, flags=0.
